axi_bram_port_arb: RTL and testbench
====================================

Name: axi_bram_port_arb

Overview:
- Shares a single BRAM port (port A) between two native-BRAM requesters: M0 is the AXI write-channel engine and M1 the AXI read-channel engine.
- Used when the controller is built with C_SINGLE_PORT_BRAM=1.
- Round-robin arbitration with burst lock, one access per cycle, registered BRAM drive.
- Tracks the owner of each read so returned data is steered to the correct requester.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, BRAM address width (byte address)
C_S_AXI_DATA_WIDTH, 32, BRAM data width; write-enable width is C_S_AXI_DATA_WIDTH/8
C_BRAM_RD_LATENCY, 1, BRAM read latency in clocks; legal values 1 or 2

Ports:
S_AXI_ACLK  in  1  clock for all logic
S_AXI_ARESETN  in  1  synchronous active-low reset
M0_Req / M1_Req  in  1  access request
M0_Lock / M1_Lock  in  1  hold grant after this beat (burst continues)
M0_WE / M1_WE  in  DW/8  byte write enables; all-zero means read
M0_Addr / M1_Addr  in  AW  byte address
M0_WrData / M1_WrData  in  DW  write data
M0_Ack / M1_Ack  out  1  request accepted this cycle (combinational)
M0_RdValid / M1_RdValid  out  1  read data valid for this requester
M0_RdData / M1_RdData  out  DW  read data
BRAM_Rst_A  out  1  equals ~S_AXI_ARESETN
BRAM_Clk_A  out  1  equals S_AXI_ACLK
BRAM_En_A  out  1  port enable (registered)
BRAM_WE_A  out  DW/8  byte write enables (registered)
BRAM_Addr_A  out  AW  address (registered)
BRAM_WrData_A  out  DW  write data (registered)
BRAM_RdData_A  in  DW  BRAM read data

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESETN is synchronous and active-low.
- Reset values:
  - BRAM_En_A=0, BRAM_WE_A=0, BRAM_Addr_A=0, BRAM_WrData_A=0.
  - Lock state = none; last-grant pointer = M1, so M0 wins the first tie.
  - Read-tag pipeline cleared; both RdValid=0.
  - Ack outputs are 0 while reset is asserted.
- Acceptance: a beat is accepted in the cycle where Mx_Req && Mx_Ack. At most one Ack per cycle. Req may drop without being acked; there is no commitment.
- Grant rules, evaluated combinationally each cycle:
  1. Lock held by Mx: only Mx may be acked. The other requester gets Ack=0 even if Mx_Req=0 (gaps inside a burst keep ownership).
  2. No lock, one requester: ack it.
  3. No lock, both requesting: ack the requester not equal to the last-grant pointer.
- Pointer and lock update on every accepted beat:
  - Pointer is set to the accepted master.
  - Lock is set to that master if its Mx_Lock=1, otherwise cleared.
  - The lock therefore releases on the first accepted beat with Lock=0.
- BRAM drive:
  - On an accepted beat, the next clock loads BRAM_En_A=1 and the winner's WE/Addr/WrData.
  - Cycles with no accept load BRAM_En_A=0 and BRAM_WE_A=0; Addr and WrData hold their values.
  - Back-to-back accepts give BRAM_En_A high every cycle, i.e. full throughput.
- Read return:
  - An accepted beat with WE==0 pushes {valid, owner} into a shift pipeline.
  - Mx_RdValid is asserted exactly 1+C_BRAM_RD_LATENCY cycles after the acceptance cycle: 2 cycles for latency 1, 3 for latency 2.
  - M0_RdData and M1_RdData are both driven directly from BRAM_RdData_A. Only the owner's RdValid rises.
  - There is no read backpressure; requesters must sink data.
  - Write beats produce no RdValid.
  - Read order equals acceptance order, including across owner switches.
- Simultaneous events:
  - Read return for one master in the same cycle as acceptance for the other: both occur; the pipeline is independent of arbitration.
  - Locked owner drops Req and the other master requests: the other master stays stalled until the lock releases.
- Reset mid-operation: in-flight reads are discarded (no RdValid after reset) and the lock is released.
- Known hazard: a requester holding Lock with Req permanently low starves the other requester. Callers guarantee bursts complete.

Test Plan:
- Single read: M1_Req=1, Addr=0x10, WE=0 for one cycle → M1_Ack=1 that cycle; BRAM_En_A=1, BRAM_Addr_A=0x10 next cycle; M1_RdValid 2 cycles after accept (latency 1) with M1_RdData=BRAM_RdData_A. M0_RdValid stays 0.
- Contention after reset: M0_Req and M1_Req both held high, Lock=0 → Acks alternate M0, M1, M0, M1; BRAM_En_A continuously 1 from the second cycle.
- Burst lock: M0 writes 4 beats (WE=0xF, Lock=1,1,1,0) while M1_Req=1 throughout, with a 1-cycle M0_Req gap after beat 2 → M1_Ack=0 for all 5 cycles including the gap; M1 is acked the cycle after M0's 4th beat.
- Mixed pipeline at latency 2: accept M1 read A, M0 read B, M1 write in consecutive cycles → M1_RdValid at accept+3 for A, M0_RdValid the following cycle for B, no RdValid for the write.
- Reset mid-flight: accept a read, assert S_AXI_ARESETN=0 for one cycle the next cycle → no RdValid ever for that read; all BRAM outputs 0; first tie after reset is granted to M0.

Source files
------------

// File: rtl/axi_bram_port_arb.sv
// axi_bram_port_arb: shares one native BRAM port between the AXI write engine
// (M0) and the AXI read engine (M1). Round-robin arbitration with burst lock,
// one accepted beat per cycle, registered BRAM drive, and a read-owner tag
// pipeline that steers returned data to the requester that issued the read.
//
// Handshake: a requester raises Mx_Req with its beat fields stable. The beat is
// accepted in the cycle where Mx_Req && Mx_Ack; Ack is combinational and at most
// one Ack is high per cycle. Req may be withdrawn before it is acked. Read data
// returns on Mx_RdValid with no backpressure; the requester must sink it.
module axi_bram_port_arb #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_BRAM_RD_LATENCY  = 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            M0_Req,
  input  logic                            M0_Lock,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] M0_WE,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   M0_Addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M0_WrData,
  output logic                            M0_Ack,
  output logic                            M0_RdValid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M0_RdData,
  input  logic                            M1_Req,
  input  logic                            M1_Lock,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] M1_WE,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   M1_Addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M1_WrData,
  output logic                            M1_Ack,
  output logic                            M1_RdValid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M1_RdData,
  output logic                            BRAM_Rst_A,
  output logic                            BRAM_Clk_A,
  output logic                            BRAM_En_A,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] BRAM_WE_A,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   BRAM_Addr_A,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   BRAM_WrData_A,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   BRAM_RdData_A
);

  localparam int WEW = C_S_AXI_DATA_WIDTH / 8;
  // One stage for the registered BRAM drive plus one per BRAM read-latency clock.
  localparam int PD  = C_BRAM_RD_LATENCY + 1;

  // Lock FSM: which master (if any) owns the port for the rest of a burst.
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_t;

  lock_t         lock_q, lock_d;
  logic          last_m1_q, last_m1_d;  // last-grant pointer: 1 = M1 won last
  logic          ack0, ack1;
  logic          rd_push;
  logic [PD-1:0] rd_vld_q;
  logic [PD-1:0] rd_own_q;              // 1 = read belongs to M1

  assign BRAM_Rst_A = ~S_AXI_ARESETN;
  assign BRAM_Clk_A = S_AXI_ACLK;
  assign M0_Ack     = ack0;
  assign M1_Ack     = ack1;

  // Grant decision plus next lock/pointer; Ack already implies Req, so Ack is accept.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    lock_d    = lock_q;
    last_m1_d = last_m1_q;
    if (S_AXI_ARESETN) begin
      case (lock_q)
        LOCK_M0: ack0 = M0_Req;
        LOCK_M1: ack1 = M1_Req;
        default: begin
          if (M0_Req && M1_Req) begin
            ack0 = last_m1_q;
            ack1 = !last_m1_q;
          end else begin
            ack0 = M0_Req;
            ack1 = M1_Req;
          end
        end
      endcase
      if (ack0) begin
        last_m1_d = 1'b0;
        lock_d    = M0_Lock ? LOCK_M0 : LOCK_NONE;
      end else if (ack1) begin
        last_m1_d = 1'b1;
        lock_d    = M1_Lock ? LOCK_M1 : LOCK_NONE;
      end
    end
  end

  // Lock and pointer registers; reset leaves M0 as winner of the first tie.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      lock_q    <= LOCK_NONE;
      last_m1_q <= 1'b1;
    end else begin
      lock_q    <= lock_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Registered BRAM drive; address and write data hold while the port is idle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      BRAM_En_A     <= 1'b0;
      BRAM_WE_A     <= '0;
      BRAM_Addr_A   <= '0;
      BRAM_WrData_A <= '0;
    end else if (ack0) begin
      BRAM_En_A     <= 1'b1;
      BRAM_WE_A     <= M0_WE;
      BRAM_Addr_A   <= M0_Addr;
      BRAM_WrData_A <= M0_WrData;
    end else if (ack1) begin
      BRAM_En_A     <= 1'b1;
      BRAM_WE_A     <= M1_WE;
      BRAM_Addr_A   <= M1_Addr;
      BRAM_WrData_A <= M1_WrData;
    end else begin
      BRAM_En_A     <= 1'b0;
      BRAM_WE_A     <= '0;
    end
  end

  assign rd_push = (ack0 && (M0_WE == {WEW{1'b0}})) ||
                   (ack1 && (M1_WE == {WEW{1'b0}}));

  // Read-owner tag pipeline, aligned so the last stage coincides with BRAM data.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rd_vld_q <= '0;
      rd_own_q <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[PD-2:0], rd_push};
      rd_own_q <= {rd_own_q[PD-2:0], ack1};
    end
  end

  assign M0_RdValid = rd_vld_q[PD-1] && !rd_own_q[PD-1];
  assign M1_RdValid = rd_vld_q[PD-1] &&  rd_own_q[PD-1];
  assign M0_RdData  = BRAM_RdData_A;
  assign M1_RdData  = BRAM_RdData_A;

endmodule

// File: tb/tb_axi_bram_port_arb.sv
// Bench for axi_bram_port_arb. Two instances share one stimulus stream: read
// latency 1 (instance 1) and read latency 2 (instance 2). Acks are checked
// directly against hand-derived values; BRAM drive and read returns are checked
// by a monitor against expected queues filled when beats are issued.
module tb_axi_bram_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 16 + 4 + AW + DW;  // {due, we, addr, wrdata}
  localparam int RW = 16 + 1 + DW;       // {due, owner, rddata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus and DUT signals ----------------
  logic            m0_req = 1'b0, m0_lock = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [3:0]      m0_we = '0, m1_we = '0;
  logic [AW-1:0]   m0_addr = '0, m1_addr = '0;
  logic [DW-1:0]   m0_wd = '0, m1_wd = '0;

  logic [2:1]      m0_ack, m1_ack, m0_rdv, m1_rdv;
  logic [2:1]      bram_rst, bram_clk, bram_en;
  logic [DW-1:0]   m0_rdd [1:2];
  logic [DW-1:0]   m1_rdd [1:2];
  logic [3:0]      bram_we [1:2];
  logic [AW-1:0]   bram_addr [1:2];
  logic [DW-1:0]   bram_wd [1:2];
  logic [DW-1:0]   bram_rdd [1:2];

  axi_bram_port_arb #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_BRAM_RD_LATENCY(1)) u_dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .M0_Req(m0_req), .M0_Lock(m0_lock), .M0_WE(m0_we), .M0_Addr(m0_addr), .M0_WrData(m0_wd),
    .M0_Ack(m0_ack[1]), .M0_RdValid(m0_rdv[1]), .M0_RdData(m0_rdd[1]),
    .M1_Req(m1_req), .M1_Lock(m1_lock), .M1_WE(m1_we), .M1_Addr(m1_addr), .M1_WrData(m1_wd),
    .M1_Ack(m1_ack[1]), .M1_RdValid(m1_rdv[1]), .M1_RdData(m1_rdd[1]),
    .BRAM_Rst_A(bram_rst[1]), .BRAM_Clk_A(bram_clk[1]), .BRAM_En_A(bram_en[1]),
    .BRAM_WE_A(bram_we[1]), .BRAM_Addr_A(bram_addr[1]), .BRAM_WrData_A(bram_wd[1]),
    .BRAM_RdData_A(bram_rdd[1])
  );

  axi_bram_port_arb #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_BRAM_RD_LATENCY(2)) u_dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .M0_Req(m0_req), .M0_Lock(m0_lock), .M0_WE(m0_we), .M0_Addr(m0_addr), .M0_WrData(m0_wd),
    .M0_Ack(m0_ack[2]), .M0_RdValid(m0_rdv[2]), .M0_RdData(m0_rdd[2]),
    .M1_Req(m1_req), .M1_Lock(m1_lock), .M1_WE(m1_we), .M1_Addr(m1_addr), .M1_WrData(m1_wd),
    .M1_Ack(m1_ack[2]), .M1_RdValid(m1_rdv[2]), .M1_RdData(m1_rdd[2]),
    .BRAM_Rst_A(bram_rst[2]), .BRAM_Clk_A(bram_clk[2]), .BRAM_En_A(bram_en[2]),
    .BRAM_WE_A(bram_we[2]), .BRAM_Addr_A(bram_addr[2]), .BRAM_WrData_A(bram_wd[2]),
    .BRAM_RdData_A(bram_rdd[2])
  );

  // BRAM models: read word is 0xD000_0000 | address, delayed by the port latency.
  logic [DW-1:0] b1_s1 = '0, b2_s1 = '0, b2_s2 = '0;
  always @(posedge clk) begin
    if (bram_en[1]) b1_s1 <= 32'hD000_0000 | bram_addr[1];
    if (bram_en[2]) b2_s1 <= 32'hD000_0000 | bram_addr[2];
    b2_s2 <= b2_s1;
  end
  assign bram_rdd[1] = b1_s1;
  assign bram_rdd[2] = b2_s2;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_bram_q[$];
  logic [RW-1:0] exp_rd_q1[$];
  logic [RW-1:0] exp_rd_q2[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: expected event did not occur by cycle %0d", name, cyc);
  endtask

  // Expected effects of a beat accepted in the current cycle.
  task automatic push_beat(input logic owner, input logic [3:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_bram_q.push_back({16'(cyc + 1), we, a, d});
    if (we == 4'h0) begin
      exp_rd_q1.push_back({16'(cyc + 2), owner, 32'hD000_0000 | a});
      exp_rd_q2.push_back({16'(cyc + 3), owner, 32'hD000_0000 | a});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rn,
                       input logic r0, input logic l0, input logic [3:0] we0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic l1, input logic [3:0] we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic e0, input logic e1, input string tag);
    @(posedge clk);
    #1;
    rst_n = rn;
    m0_req = r0; m0_lock = l0; m0_we = we0; m0_addr = a0; m0_wd = d0;
    m1_req = r1; m1_lock = l1; m1_we = we1; m1_addr = a1; m1_wd = d1;
    @(negedge clk);
    #1;
    check({tag, " lat1 acks"}, {m0_ack[1], m1_ack[1]}, {e0, e1});
    check({tag, " lat2 acks"}, {m0_ack[2], m1_ack[2]}, {e0, e1});
    if (e0) push_beat(1'b0, we0, a0, d0);
    else if (e1) push_beat(1'b1, we1, a1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, "idle");
  endtask

  task automatic check_bram_zero(input string tag);
    for (int k = 1; k <= 2; k++) begin
      check({tag, " bram en"},   bram_en[k],   1'b0);
      check({tag, " bram we"},   bram_we[k],   4'h0);
      check({tag, " bram addr"}, bram_addr[k], 32'h0);
      check({tag, " bram wd"},   bram_wd[k],   32'h0);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_rd(input int k, input logic v0, input logic v1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [RW-1:0] q[$];
    logic [RW-1:0] e;
    if (k == 1) q = exp_rd_q1; else q = exp_rd_q2;
    while (q.size() > 0 && q[0][RW-1 -: 16] < 16'(cyc)) begin
      fail_bound(k == 1 ? "lat1 rdvalid" : "lat2 rdvalid");
      void'(q.pop_front());
    end
    if (v0 || v1) begin
      if (q.size() == 0) begin
        check(k == 1 ? "lat1 unexpected rdvalid" : "lat2 unexpected rdvalid", {v0, v1}, 2'b00);
      end else begin
        e = q.pop_front();
        check(k == 1 ? "lat1 rd cycle" : "lat2 rd cycle", 16'(cyc), e[RW-1 -: 16]);
        check(k == 1 ? "lat1 rd owner" : "lat2 rd owner", {v0, v1}, e[DW] ? 2'b01 : 2'b10);
        check(k == 1 ? "lat1 rd data" : "lat2 rd data", e[DW] ? d1 : d0, e[DW-1:0]);
      end
    end
    if (k == 1) exp_rd_q1 = q; else exp_rd_q2 = q;
  endtask

  // Pops and compares whenever the BRAM port fires or a read returns.
  always @(negedge clk) begin
    logic [BW-1:0] e;
    while (exp_bram_q.size() > 0 && exp_bram_q[0][BW-1 -: 16] < 16'(cyc)) begin
      fail_bound("bram en");
      void'(exp_bram_q.pop_front());
    end
    if (bram_en[1] === 1'b1 || bram_en[2] === 1'b1) begin
      if (exp_bram_q.size() == 0) begin
        check("unexpected bram en", {bram_en[1], bram_en[2]}, 2'b00);
      end else begin
        e = exp_bram_q.pop_front();
        check("bram cycle", 16'(cyc), e[BW-1 -: 16]);
        for (int k = 1; k <= 2; k++) begin
          check("bram en",   bram_en[k],   1'b1);
          check("bram we",   bram_we[k],   e[AW+DW+3 -: 4]);
          check("bram addr", bram_addr[k], e[AW+DW-1 -: AW]);
          check("bram wd",   bram_wd[k],   e[DW-1:0]);
        end
      end
    end
    mon_rd(1, m0_rdv[1] === 1'b1, m1_rdv[1] === 1'b1, m0_rdd[1], m1_rdd[1]);
    mon_rd(2, m0_rdv[2] === 1'b1, m1_rdv[2] === 1'b1, m0_rdd[2], m1_rdd[2]);
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    // Reset: Acks stay low even with both requesting; BRAM outputs at reset values.
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, "reset idle");
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, "reset idle");
    drive(0, 1, 0, 4'h0, 32'h4, 32'h0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 0, "reset req");
    check_bram_zero("reset");
    check("reset rdvalid", {m0_rdv, m1_rdv}, 4'h0);

    // Single M1 read of 0x10.
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 1, "single read");
    idle(4);

    // Contention: tie goes to M0 first, then alternates.
    drive(1, 1, 0, 4'h0, 32'h20, 32'h0, 1, 0, 4'h0, 32'h40, 32'h0, 1, 0, "rr beat1");
    drive(1, 1, 0, 4'h0, 32'h24, 32'h0, 1, 0, 4'h0, 32'h44, 32'h0, 0, 1, "rr beat2");
    drive(1, 1, 0, 4'h0, 32'h28, 32'h0, 1, 0, 4'h0, 32'h48, 32'h0, 1, 0, "rr beat3");
    drive(1, 1, 0, 4'h0, 32'h2C, 32'h0, 1, 0, 4'h0, 32'h4C, 32'h0, 0, 1, "rr beat4");
    idle(4);

    // M0 locked write burst with a request gap; M1 waits until the lock releases.
    drive(1, 1, 1, 4'hF, 32'h100, 32'h1111_1111, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, "burst b1");
    drive(1, 1, 1, 4'hF, 32'h104, 32'h2222_2222, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, "burst b2");
    drive(1, 0, 1, 4'hF, 32'h104, 32'h2222_2222, 1, 0, 4'h0, 32'h80, 32'h0, 0, 0, "burst gap");
    drive(1, 1, 1, 4'hF, 32'h108, 32'h3333_3333, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, "burst b3");
    drive(1, 1, 0, 4'hF, 32'h10C, 32'h4444_4444, 1, 0, 4'h0, 32'h80, 32'h0, 1, 0, "burst b4");
    drive(1, 0, 0, 4'h0, 32'h0,   32'h0,         1, 0, 4'h0, 32'h80, 32'h0, 0, 1, "after burst");
    idle(4);

    // Mixed: M1 read A, M0 read B, M1 write, back to back.
    drive(1, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 4'h0, 32'h200, 32'h0,         0, 1, "mixed rdA");
    drive(1, 1, 0, 4'h0, 32'h204, 32'h0, 0, 0, 4'h0, 32'h0,   32'h0,         1, 0, "mixed rdB");
    drive(1, 0, 0, 4'h0, 32'h0,   32'h0, 1, 0, 4'h3, 32'h208, 32'h5555_AAAA, 0, 1, "mixed wr");
    idle(5);

    // Reset mid-flight: M1 locked read accepted, then one reset cycle.
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'h0, 32'h300, 32'h0, 0, 1, "flight read");
    void'(exp_rd_q1.pop_back());
    void'(exp_rd_q2.pop_back());
    drive(0, 1, 0, 4'h0, 32'h304, 32'h0, 1, 1, 4'h0, 32'h308, 32'h0, 0, 0, "flight reset");
    drive(1, 1, 0, 4'h0, 32'h310, 32'h0, 1, 0, 4'h0, 32'h410, 32'h0, 1, 0, "post reset tie");
    check_bram_zero("post reset");
    drive(1, 1, 0, 4'h0, 32'h314, 32'h0, 1, 0, 4'h0, 32'h414, 32'h0, 0, 1, "post reset rr");
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
